ball_horizontal_gen: RTL and testbench
======================================

Name: ball_horizontal_gen

Overview:
- Parametrised horizontal ball engine.
- Merges move timing, direction latch, hit-driven speed-up and horizontal video window into one synchronous block clocked by the pixel clock.
- Adds configurable playfield width, ball width, base speed and speed-level count, plus attract-mode wall bounce and off-screen miss pulses.
- Feeds the video mixer (hvid_n) and scoring logic (miss_l/miss_r).

Parameters:
- PW, 9, position/pixel-counter width in bits
- H_ACTIVE, 256, active pixels per line; legal position range 0..H_ACTIVE-BALL_W
- BALL_W, 4, ball width in pixels (1..15)
- BASE_SPEED, 1, pixels moved per frame at speed level 0
- SPEED_LEVELS, 3, number of speed levels (>=1)
- HITS_PER_LEVEL, 4, paddle hits needed per speed-level increment

Ports:
- clk7_159  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- _hblank  in  1  low during horizontal blank
- vreset  in  1  one-clock frame-start pulse
- hit1  in  1  one-clock pulse, left paddle hit
- hit2  in  1  one-clock pulse, right paddle hit
- rst_speed  in  1  level-sensitive speed reset
- serve  in  1  high = ball in play
- attract  in  1  high = attract mode
- l  out  1  ball moving left
- r  out  1  ball moving right (always ~l)
- hpos  out  PW  current ball left-edge position
- speed_level  out  ceil(log2(SPEED_LEVELS+1))  current level
- miss_l  out  1  one-clock pulse, ball exited left edge
- miss_r  out  1  one-clock pulse, ball exited right edge
- _hvid  out  1  active-low ball horizontal video

Behaviour:
- Reset (async, all outputs and state):
  - hpos = CENTRE = (H_ACTIVE-BALL_W)/2 (integer divide); r=1, l=0
  - hit count = 0, speed_level = 0, miss_l = miss_r = 0, _hvid = 1, pixel counter = 0, parked = 0
- Pixel counter hcnt (PW bits):
  - cleared on any clk while _hblank = 0; increments by 1 each clk while _hblank = 1
  - saturates at all-ones, no wrap
- Video: _hvid registered, 1-clk latency.
  - next _hvid = 0 iff _hblank=1 && serve=1 && parked=0 && hpos <= hcnt < hpos+BALL_W; otherwise 1.
- Direction (evaluated every clk, registered):
  - hit1 alone -> r=1; hit2 alone -> r=0; hit1 && hit2 same clk -> direction unchanged.
  - l = ~r always.
- Hit counter:
  - counts clocks with (hit1 || hit2), i.e. simultaneous hits count once
  - saturates at HITS_PER_LEVEL*(SPEED_LEVELS-1)
  - speed_level = hitcount / HITS_PER_LEVEL
  - rst_speed=1 forces hitcount=0 and overrides a hit in the same clk
- Move on vreset=1 when serve=1 and parked=0:
  - step = BASE_SPEED + speed_level
  - the step uses the direction as updated in the same clk, i.e. a hit on the same clk as vreset takes effect immediately
  - arithmetic is in PW+1 bits, signed intent
  - moving right with hpos+step > H_ACTIVE-BALL_W:
    - attract=1: hpos = H_ACTIVE-BALL_W, r <- 0 (bounce)
    - attract=0: miss_r pulses for 1 clk, parked=1, hpos unchanged
  - moving left with step > hpos:
    - attract=1: hpos = 0, r <- 1
    - attract=0: miss_l pulses, parked=1
  - exact landing on a boundary (0 or H_ACTIVE-BALL_W) is legal and is not a miss/bounce
- Serve:
  - rising edge of serve (registered compare) -> hpos = CENTRE, parked = 0
  - direction and speed are kept
  - a serve rising edge coinciding with vreset has priority; no move that frame
- serve=0: hpos frozen, no misses, video off.
- attract=1 never produces miss pulses.
- miss_l/miss_r are never both high; each is high for exactly 1 clk per exit.
- Reset asserted mid-frame or mid-line returns everything to reset values immediately. After deassertion, behaviour resumes at the next vreset.

Test Plan:
- Reset release, serve 0->1, no hits, 10 vreset pulses (defaults) -> hpos 126 -> 136, r=1, speed_level=0.
- 4 hit1 pulses then 4 hit2 pulses, then vreset -> speed_level 2, l=1, hpos decreases by 3 per frame; 4 further hits leave speed_level saturated at 2.
- hit1 && hit2 same clk while l=1 -> l stays 1, hitcount +1. Assert rst_speed during a hit -> speed_level=0.
- attract=1, hpos=251, r=1, speed 2 -> next vreset hpos=252, r=0, no miss pulse. Mirror case at left edge: hpos=1, step 3 -> hpos=0, r=1.
- attract=0, r=1, hpos=251, step 3 -> miss_r single 1-clk pulse, hpos holds 251, _hvid stays 1. Then serve 1->0->1 -> hpos=126, ball visible again.
- Line with hpos=40, serve=1: _hblank rises at clk t -> _hvid low for exactly 4 clks, starting one clk after hcnt reaches 40. Reset asserted mid-ball -> _hvid=1 immediately.

Source files
------------

// File: rtl/ball_horizontal_gen.sv
// Horizontal ball engine: move timing, direction latch, hit-driven speed-up,
// attract-mode wall bounce, off-screen miss pulses and horizontal video window.
// Ports:
//   clk7_159     pixel clock
//   reset        asynchronous active-high reset
//   _hblank      low during horizontal blank
//   vreset       one-clock frame-start pulse (moves happen here)
//   hit1/hit2    one-clock paddle hit pulses (left/right paddle)
//   rst_speed    level-sensitive speed reset
//   serve        ball in play; attract: attract mode (walls bounce)
//   l/r          ball direction (l = ~r)
//   hpos         ball left-edge position
//   speed_level  current speed level
//   miss_l/r     one-clock exit pulses
//   _hvid        active-low ball horizontal video (1-clk latency)
module ball_horizontal_gen #(
    parameter int PW             = 9,
    parameter int H_ACTIVE       = 256,
    parameter int BALL_W         = 4,
    parameter int BASE_SPEED     = 1,
    parameter int SPEED_LEVELS   = 3,
    parameter int HITS_PER_LEVEL = 4,
    localparam int SW            = $clog2(SPEED_LEVELS + 1)
) (
    input  logic          clk7_159,
    input  logic          reset,
    input  logic          _hblank,
    input  logic          vreset,
    input  logic          hit1,
    input  logic          hit2,
    input  logic          rst_speed,
    input  logic          serve,
    input  logic          attract,
    output logic          l,
    output logic          r,
    output logic [PW-1:0] hpos,
    output logic [SW-1:0] speed_level,
    output logic          miss_l,
    output logic          miss_r,
    output logic          _hvid
);

    localparam int MAXP   = H_ACTIVE - BALL_W;
    localparam int CENTRE = MAXP / 2;
    localparam int HMAX   = HITS_PER_LEVEL * (SPEED_LEVELS - 1);
    localparam int HW     = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

    // One extra bit so over/underflow of a move is visible.
    typedef logic [PW:0] ext_t;

    logic [PW-1:0] hcnt;
    logic [HW-1:0] hc;
    logic          parked;
    logic          serve_q;

    logic          rise;
    logic          r_dir;
    logic          move;
    logic          over_r;
    logic          over_l;
    logic          in_ball;
    ext_t          pos_x;
    ext_t          step;
    ext_t          sum_r;
    ext_t          diff_l;

    logic [PW-1:0] hpos_n;
    logic          r_n;
    logic          parked_n;
    logic          miss_l_n;
    logic          miss_r_n;

    assign l           = ~r;
    assign speed_level = SW'(32'(hc) / HITS_PER_LEVEL);

    always_comb begin
        rise  = serve & ~serve_q;
        r_dir = r;
        if (hit1 & ~hit2)
            r_dir = 1'b1;
        else if (hit2 & ~hit1)
            r_dir = 1'b0;

        pos_x  = {1'b0, hpos};
        step   = ext_t'(BASE_SPEED) + ext_t'(speed_level);
        sum_r  = pos_x + step;
        diff_l = pos_x - step;
        // A serve edge on the same clock as vreset wins: no move that frame.
        move   = vreset & serve & ~parked & ~rise;
        over_r = r_dir & (sum_r > ext_t'(MAXP));
        over_l = ~r_dir & (step > pos_x);

        in_ball = _hblank & serve & ~parked
                & ({1'b0, hcnt} >= pos_x)
                & ({1'b0, hcnt} < pos_x + ext_t'(BALL_W));

        hpos_n   = hpos;
        r_n      = r_dir;
        parked_n = parked;
        miss_l_n = 1'b0;
        miss_r_n = 1'b0;

        if (rise) begin
            hpos_n   = PW'(CENTRE);
            parked_n = 1'b0;
        end else if (move) begin
            if (over_r) begin
                if (attract) begin
                    hpos_n = PW'(MAXP);
                    r_n    = 1'b0;
                end else begin
                    miss_r_n = 1'b1;
                    parked_n = 1'b1;
                end
            end else if (over_l) begin
                if (attract) begin
                    hpos_n = '0;
                    r_n    = 1'b1;
                end else begin
                    miss_l_n = 1'b1;
                    parked_n = 1'b1;
                end
            end else if (r_dir) begin
                hpos_n = sum_r[PW-1:0];
            end else begin
                hpos_n = diff_l[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk7_159 or posedge reset) begin
        if (reset) begin
            hpos    <= PW'(CENTRE);
            r       <= 1'b1;
            hc      <= '0;
            parked  <= 1'b0;
            serve_q <= 1'b0;
            miss_l  <= 1'b0;
            miss_r  <= 1'b0;
            _hvid   <= 1'b1;
            hcnt    <= '0;
        end else begin
            hpos    <= hpos_n;
            r       <= r_n;
            parked  <= parked_n;
            serve_q <= serve;
            miss_l  <= miss_l_n;
            miss_r  <= miss_r_n;
            _hvid   <= ~in_ball;

            if (!_hblank)
                hcnt <= '0;
            else if (hcnt != '1)
                hcnt <= hcnt + PW'(1);

            if (rst_speed)
                hc <= '0;
            else if ((hit1 | hit2) && (32'(hc) < HMAX))
                hc <= hc + HW'(1);
        end
    end

endmodule

// File: tb/tb_ball_horizontal_gen.sv
// Self-checking bench for ball_horizontal_gen: directed scenarios with
// literal expectations plus randomized stimulus against a behavioural model.
module tb_ball_horizontal_gen;

    localparam int PW   = 9;
    localparam int HA   = 256;
    localparam int BW   = 4;
    localparam int BS   = 1;
    localparam int SL   = 3;
    localparam int HPL  = 4;
    localparam int MAXP = HA - BW;
    localparam int CEN  = MAXP / 2;
    localparam int HMAX = HPL * (SL - 1);

    logic          clk7_159 = 1'b0;
    logic          reset = 1'b0;
    logic          _hblank = 1'b0;
    logic          vreset = 1'b0;
    logic          hit1 = 1'b0;
    logic          hit2 = 1'b0;
    logic          rst_speed = 1'b0;
    logic          serve = 1'b0;
    logic          attract = 1'b0;
    logic          l;
    logic          r;
    logic [PW-1:0] hpos;
    logic [1:0]    speed_level;
    logic          miss_l;
    logic          miss_r;
    logic          _hvid;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    // Behavioural model state
    int m_pos, m_dir, m_hits, m_pix, lvl, np;
    bit m_parked, m_sprev, m_ml, m_mr, m_hvid, m_rise;

    ball_horizontal_gen #(
        .PW(PW), .H_ACTIVE(HA), .BALL_W(BW), .BASE_SPEED(BS),
        .SPEED_LEVELS(SL), .HITS_PER_LEVEL(HPL)
    ) dut (
        .clk7_159(clk7_159), .reset(reset), ._hblank(_hblank),
        .vreset(vreset), .hit1(hit1), .hit2(hit2),
        .rst_speed(rst_speed), .serve(serve), .attract(attract),
        .l(l), .r(r), .hpos(hpos), .speed_level(speed_level),
        .miss_l(miss_l), .miss_r(miss_r), ._hvid(_hvid)
    );

    always #5 clk7_159 = ~clk7_159;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    always @(posedge clk7_159 or posedge reset) begin
        if (reset) begin
            m_pos = CEN; m_dir = 1; m_hits = 0; m_pix = 0;
            m_parked = 0; m_sprev = 0; m_ml = 0; m_mr = 0; m_hvid = 1;
        end else begin
            lvl = m_hits / HPL;
            if (hit1 && !hit2) m_dir = 1;
            else if (hit2 && !hit1) m_dir = -1;
            m_hvid = !(_hblank && serve && !m_parked &&
                       m_pix >= m_pos && m_pix < m_pos + BW);
            m_pix = _hblank ? ((m_pix < 511) ? m_pix + 1 : 511) : 0;
            if (rst_speed) m_hits = 0;
            else if (hit1 || hit2) m_hits = (m_hits < HMAX) ? m_hits + 1 : HMAX;
            m_ml = 0; m_mr = 0;
            m_rise = serve && !m_sprev;
            m_sprev = serve;
            if (m_rise) begin
                m_pos = CEN; m_parked = 0;
            end else if (vreset && serve && !m_parked) begin
                np = m_pos + m_dir * (BS + lvl);
                if (np > MAXP) begin
                    if (attract) begin m_pos = MAXP; m_dir = -1; end
                    else begin m_mr = 1; m_parked = 1; end
                end else if (np < 0) begin
                    if (attract) begin m_pos = 0; m_dir = 1; end
                    else begin m_ml = 1; m_parked = 1; end
                end else begin
                    m_pos = np;
                end
            end
        end
    end

    always @(negedge clk7_159) begin
        if (started && !reset) begin
            check("hpos", 32'(hpos), m_pos);
            check("r", 32'(r), 32'(m_dir > 0));
            check("l", 32'(l), 32'(m_dir < 0));
            check("speed_level", 32'(speed_level), m_hits / HPL);
            check("miss_l", 32'(miss_l), 32'(m_ml));
            check("miss_r", 32'(miss_r), 32'(m_mr));
            check("hvid", 32'(_hvid), 32'(m_hvid));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk7_159);
            #1;
        end
    endtask

    task automatic frame();
        vreset = 1; cyc(1); vreset = 0; cyc(2);
    endtask

    task automatic pulse_hit(input bit a, input bit b);
        hit1 = a; hit2 = b; cyc(1); hit1 = 0; hit2 = 0; cyc(1);
    endtask

    task automatic speed_rst();
        rst_speed = 1; cyc(1); rst_speed = 0; cyc(1);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_pos != target && guard < 400) begin
            frame();
            guard++;
        end
        check("run_to", 32'(hpos), target);
    endtask

    task automatic run_line(output int first, output int cnt);
        first = 0; cnt = 0;
        _hblank = 0; cyc(2); _hblank = 1;
        for (int k = 1; k <= 300; k++) begin
            cyc(1);
            if (!_hvid) begin
                if (first == 0) first = k;
                cnt++;
            end
        end
        _hblank = 0; cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first, cnt, lc;
        #2 reset = 1;
        started = 1;
        cyc(2);
        check("rst_hpos", 32'(hpos), 126);
        check("rst_r", 32'(r), 1);
        check("rst_l", 32'(l), 0);
        check("rst_speed", 32'(speed_level), 0);
        check("rst_hvid", 32'(_hvid), 1);
        check("rst_miss", 32'({miss_l, miss_r}), 0);
        reset = 0; cyc(1);

        serve = 1; cyc(1);
        repeat (10) frame();
        check("ten_frames_hpos", 32'(hpos), 136);
        check("ten_frames_r", 32'(r), 1);

        repeat (4) pulse_hit(1, 0);
        repeat (4) pulse_hit(0, 1);
        frame();
        check("speed2_level", 32'(speed_level), 2);
        check("speed2_l", 32'(l), 1);
        check("speed2_hpos", 32'(hpos), 133);
        frame();
        check("speed2_hpos2", 32'(hpos), 130);
        repeat (4) pulse_hit(0, 1);
        check("speed_sat", 32'(speed_level), 2);

        speed_rst();
        pulse_hit(1, 1);
        check("dual_hit_l", 32'(l), 1);
        repeat (2) pulse_hit(0, 1);
        check("dual_once_lvl0", 32'(speed_level), 0);
        pulse_hit(0, 1);
        check("dual_once_lvl1", 32'(speed_level), 1);
        rst_speed = 1; hit2 = 1; cyc(1); rst_speed = 0; hit2 = 0; cyc(1);
        check("rst_speed_hit", 32'(speed_level), 0);
        repeat (3) pulse_hit(0, 1);
        check("rst_speed_override", 32'(speed_level), 0);

        pulse_hit(1, 0);
        speed_rst();
        run_to(251);
        repeat (8) pulse_hit(1, 0);
        attract = 1;
        frame();
        check("bounce_r_hpos", 32'(hpos), 252);
        check("bounce_r_dir", 32'(r), 0);

        speed_rst();
        pulse_hit(0, 1);
        run_to(1);
        repeat (7) pulse_hit(0, 1);
        frame();
        check("bounce_l_hpos", 32'(hpos), 0);
        check("bounce_l_dir", 32'(r), 1);
        attract = 0;

        speed_rst();
        pulse_hit(1, 0);
        run_to(251);
        repeat (7) pulse_hit(1, 0);
        vreset = 1; cyc(1); vreset = 0;
        check("miss_r_pulse", 32'(miss_r), 1);
        check("miss_r_hpos", 32'(hpos), 251);
        cyc(1);
        check("miss_r_single", 32'(miss_r), 0);
        run_line(first, cnt);
        check("parked_no_video", cnt, 0);
        serve = 0; cyc(2); serve = 1; cyc(1);
        check("reserve_hpos", 32'(hpos), 126);
        run_line(first, cnt);
        check("reserve_video_cnt", cnt, 4);
        check("reserve_video_first", first, 127);

        pulse_hit(0, 1);
        speed_rst();
        run_to(40);
        run_line(first, cnt);
        check("line40_first", first, 41);
        check("line40_cnt", cnt, 4);
        _hblank = 0; cyc(2); _hblank = 1; cyc(42);
        check("mid_ball_low", 32'(_hvid), 0);
        reset = 1; #1;
        check("async_rst_hvid", 32'(_hvid), 1);
        check("async_rst_hpos", 32'(hpos), 126);
        cyc(2);
        reset = 0; _hblank = 0; cyc(2);

        lc = 0;
        for (int i = 0; i < 5000; i++) begin
            if (lc == 0) begin
                _hblank = !_hblank;
                lc = _hblank ? $urandom_range(150, 300) : $urandom_range(5, 20);
            end else begin
                lc--;
            end
            vreset    = ($urandom_range(0, 7) == 0);
            hit1      = ($urandom_range(0, 15) == 0);
            hit2      = ($urandom_range(0, 15) == 0);
            rst_speed = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) serve = !serve;
            if ($urandom_range(0, 399) == 0) attract = !attract;
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1; cyc(2); reset = 0;
            end
            cyc(1);
        end
        vreset = 0; hit1 = 0; hit2 = 0; rst_speed = 0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
